// File: rtl/cpu_pkg.sv
// Shared control-path constants: opcodes, microcode-address geometry and field offsets.
// Pure definitions, no logic, so latency and backpressure do not apply.
package cpu_pkg;

    localparam int OPW    = 4;
    localparam int STEPW  = 3;
    localparam int STEPS  = 5;
    localparam int ADDR_W = 9;

    localparam logic [OPW-1:0] OP_LDA = 4'h0;
    localparam logic [OPW-1:0] OP_ADD = 4'h1;
    localparam logic [OPW-1:0] OP_SUB = 4'h2;
    localparam logic [OPW-1:0] OP_STA = 4'h3;
    localparam logic [OPW-1:0] OP_LDI = 4'h5;
    localparam logic [OPW-1:0] OP_JMP = 4'h6;
    localparam logic [OPW-1:0] OP_JC  = 4'h7;
    localparam logic [OPW-1:0] OP_JZ  = 4'h8;
    localparam logic [OPW-1:0] OP_OUT = 4'hE;
    localparam logic [OPW-1:0] OP_HLT = 4'hF;

    // Bit positions inside the microcode address {opcode, step, cf, zf}.
    localparam int CU_ZF_BIT   = 0;
    localparam int CU_CF_BIT   = 1;
    localparam int CU_STEP_LSB = 2;
    localparam int CU_OP_LSB   = CU_STEP_LSB + STEPW;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [STEPW-1:0] step;
        logic             cf;
        logic             zf;
    } cu_addr_t;

    function automatic cu_addr_t pack_cu_addr(input logic [OPW-1:0]   opcode,
                                              input logic [STEPW-1:0] step,
                                              input logic             cf,
                                              input logic             zf);
        cu_addr_t a;
        a.opcode = opcode;
        a.step   = step;
        a.cf     = cf;
        a.zf     = zf;
        return a;
    endfunction

endpackage

// File: rtl/instr_sequencer_step_counter.sv
// Microstep counter wrapping STEPS-1 -> 0; updates one edge after its controls.
// Backpressure: none; priority is force-zero > hold > clear > increment.
module step_counter
    import cpu_pkg::*;
#(
    parameter int STEPS_P = 5,
    parameter int STEPW_P = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               zero_i,
    input  logic               hold_i,
    input  logic               clr_i,
    output logic [STEPW_P-1:0] step_o
);

    localparam logic [STEPW_P-1:0] LAST = STEPW_P'(STEPS_P - 1);
    localparam logic [STEPW_P-1:0] ONE  = STEPW_P'(1);

    logic [STEPW_P-1:0] count_q;
    logic [STEPW_P-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (zero_i) begin
            count_d = '0;
        end else if (hold_i) begin
            count_d = count_q;
        end else if (clr_i || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step_o = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction register, microstep counter, ALU flags and halt/program-mode control; 1-edge latency.
// Backpressure: none; cu_addr is a pure concatenation of registers, priority pmode > halted > step_clr > increment.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int STEPS = 5,
    parameter int OPW   = 4,
    parameter int STEPW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pmode,
    input  logic [7:0]       bus_in,
    input  logic             ir_load,
    input  logic             step_clr,
    input  logic             halt,
    input  logic             flag_load,
    input  logic             carry_in,
    input  logic             zero_in,
    output logic [8:0]       cu_addr,
    output logic             cu_pmode,
    output logic [3:0]       ir_operand,
    output logic [STEPW-1:0] step,
    output logic             halted
);

    if (OPW + STEPW + 2 != 9) begin : g_bad_addr_width
        $fatal(1, "instr_sequencer: OPW+STEPW+2 must equal 9");
    end
    if (STEPS > (1 << STEPW)) begin : g_bad_steps
        $fatal(1, "instr_sequencer: STEPS does not fit in STEPW bits");
    end
    if (STEPS < 2) begin : g_too_few_steps
        $fatal(1, "instr_sequencer: STEPS must be at least 2");
    end

    logic       run_q;
    logic [7:0] ir_q, ir_d;
    logic       cf_q, cf_d;
    logic       zf_q, zf_d;
    logic       halted_q, halted_d;
    logic       pmode_q;
    logic       load_en;
    logic       cnt_hold;

    // run_q delays the first increment until one full edge after reset release.
    assign load_en  = run_q && !pmode && !halted_q;
    assign cnt_hold = !run_q || halted_q || halt;

    always_comb begin
        ir_d     = ir_q;
        cf_d     = cf_q;
        zf_d     = zf_q;
        halted_d = halted_q;
        if (load_en && ir_load) begin
            ir_d = bus_in;
        end
        if (load_en && flag_load) begin
            cf_d = carry_in;
            zf_d = zero_in;
        end
        if (pmode) begin
            halted_d = 1'b0;
        end else if (run_q && halt) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            ir_q     <= 8'h00;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            halted_q <= 1'b0;
            pmode_q  <= 1'b1;
        end else begin
            run_q    <= 1'b1;
            ir_q     <= ir_d;
            cf_q     <= cf_d;
            zf_q     <= zf_d;
            halted_q <= halted_d;
            pmode_q  <= pmode;
        end
    end

    step_counter #(
        .STEPS_P (STEPS),
        .STEPW_P (STEPW)
    ) u_step_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .zero_i (pmode),
        .hold_i (cnt_hold),
        .clr_i  (step_clr),
        .step_o (step)
    );

    assign cu_addr    = {ir_q[7 -: OPW], step, cf_q, zf_q};
    assign cu_pmode   = pmode_q;
    assign ir_operand = ir_q[3:0];
    assign halted     = halted_q;

endmodule
